// File: rtl/mat_result_serializer.sv
// mat_result_serializer
// Buffers {w,x,y,z} result sets from the 2x2 matrix multiplier in a small FIFO
// and replays them as a valid/ready word stream (w, x, y, z order, last on z).
// The multiplier cannot be stalled, so a set that finds no room is dropped and
// the sticky overflow flag is raised.
module mat_result_serializer #(
   parameter int DEPTH = 4,
   parameter int DW    = 32
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         done,
   input  logic signed [DW-1:0]         w,
   input  logic signed [DW-1:0]         x,
   input  logic signed [DW-1:0]         y,
   input  logic signed [DW-1:0]         z,
   input  logic                         clr_ovf,
   output logic [DW-1:0]                out_data,
   output logic [1:0]                   out_idx,
   output logic                         out_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         full,
   output logic                         overflow
);

   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Read FSM encoding: state minus one is the element index being sent.
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SEND_W = 3'd1;
   localparam logic [2:0] SEND_X = 3'd2;
   localparam logic [2:0] SEND_Y = 3'd3;
   localparam logic [2:0] SEND_Z = 3'd4;

   // Each entry holds a whole set; element e lives at bits [e*DW +: DW].
   logic [4*DW-1:0] mem_q [DEPTH];

   logic [2:0]      state_q, state_d;
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [LW-1:0]   level_q, level_d;
   logic            overflow_q, overflow_d;
   logic [DW-1:0]   out_data_q, out_data_d;

   logic            sending;
   logic            hs;
   logic            pop;
   logic            push;
   logic            drop;
   logic [4*DW-1:0] in_set;
   logic [4*DW-1:0] head_set;
   logic [LW-1:0]   remain;
   logic [1:0]      elem_d;

   assign sending = (state_q != IDLE);
   assign hs      = sending && out_ready;
   assign pop     = hs && (state_q == SEND_Z);
   // A full FIFO can still take a set when the head leaves on the same edge.
   assign push    = done && ((level_q < LW'(DEPTH)) || pop);
   assign drop    = done && !push;
   assign in_set  = {z, y, x, w};

   // Next-state, pointer, level and output-word computation.
   always_comb begin
      state_d    = state_q;
      head_d     = head_q + PW'(pop);
      tail_d     = tail_q + PW'(push);
      level_d    = level_q + LW'(push) - LW'(pop);
      overflow_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
      remain     = level_q - LW'(pop);
      // When nothing else is left after this edge's pop, the new head is the
      // set arriving right now, which is not yet in storage.
      head_set   = (remain == '0) ? in_set : mem_q[head_d];

      case (state_q)
         IDLE:    if (push) state_d = SEND_W;
         SEND_W:  if (hs) state_d = SEND_X;
         SEND_X:  if (hs) state_d = SEND_Y;
         SEND_Y:  if (hs) state_d = SEND_Z;
         SEND_Z:  if (hs) state_d = (level_d != '0) ? SEND_W : IDLE;
         default: state_d = IDLE;
      endcase

      elem_d = 2'(state_d - 3'd1);
      if (state_d == IDLE) begin
         out_data_d = '0;
      end else if (state_d != state_q) begin
         out_data_d = head_set[elem_d*DW +: DW];
      end else begin
         out_data_d = out_data_q;
      end
   end

   // Set storage; reset only clears the pointers, so stale contents are unreachable.
   always_ff @(posedge clk) begin
      if (push) mem_q[tail_q] <= in_set;
   end

   // Control and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         head_q     <= '0;
         tail_q     <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         out_data_q <= out_data_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = sending;
   assign out_last  = (state_q == SEND_Z);
   assign out_idx   = sending ? 2'(state_q - 3'd1) : 2'd0;
   assign level     = level_q;
   assign full      = (level_q == LW'(DEPTH));
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_mat_result_serializer.sv
// Bench for mat_result_serializer: expected words are queued when a set is
// issued and compared against every accepted stream word.
module tb_mat_result_serializer;

   localparam int DEPTH = 4;
   localparam int DW    = 32;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  idx;
      logic        last;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              done = 1'b0;
   logic signed [DW-1:0] w = '0, x = '0, y = '0, z = '0;
   logic              clr_ovf = 1'b0;
   logic [DW-1:0]     out_data;
   logic [1:0]        out_idx;
   logic              out_last;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [2:0]        level;
   logic              full;
   logic              overflow;

   int n_checks = 0;
   int n_fail   = 0;
   int hs_cnt   = 0;
   exp_t sb[$];

   mat_result_serializer #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk(clk), .reset_n(reset_n), .done(done),
      .w(w), .x(x), .y(y), .z(z), .clr_ovf(clr_ovf),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .level(level), .full(full), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Stream monitor: scoreboard compare on handshakes, hold check under backpressure.
   logic [31:0] prev_data;
   logic [1:0]  prev_idx;
   bit          hold_pend = 1'b0;
   always @(negedge clk) begin : mon
      exp_t e;
      if (!reset_n) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== prev_data || out_idx !== prev_idx) begin
               n_fail++;
               $display("FAIL hold: valid=%b data=%h idx=%0d, required valid=1 data=%h idx=%0d",
                        out_valid, out_data, out_idx, prev_data, prev_idx);
            end
         end
         if (out_valid === 1'b1) begin
            if (out_ready) begin
               hs_cnt++;
               n_checks++;
               if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_word: data=%h idx=%0d with empty scoreboard", out_data, out_idx);
               end else begin
                  e = sb.pop_front();
                  if (out_data !== e.data || out_idx !== e.idx || out_last !== e.last) begin
                     n_fail++;
                     $display("FAIL word: got data=%h idx=%0d last=%b, required data=%h idx=%0d last=%b",
                              out_data, out_idx, out_last, e.data, e.idx, e.last);
                  end else begin
                     $display("word data=%h idx=%0d last=%b", out_data, out_idx, out_last);
                  end
               end
            end
            hold_pend = !out_ready;
            prev_data = out_data;
            prev_idx  = out_idx;
         end else begin
            hold_pend = 1'b0;
            n_checks++;
            if (out_data !== '0) begin
               n_fail++;
               $display("FAIL idle_data: got %h, required 0", out_data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d);
      sb.push_back('{data: a, idx: 2'd0, last: 1'b0});
      sb.push_back('{data: b, idx: 2'd1, last: 1'b0});
      sb.push_back('{data: c, idx: 2'd2, last: 1'b0});
      sb.push_back('{data: d, idx: 2'd3, last: 1'b1});
   endtask

   task automatic set_in(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
      w = a; x = b; y = c; z = d;
   endtask

   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (sb.size() == 0 && out_valid === 1'b0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if (out_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0 || full !== 1'b0 || out_data !== '0) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b level=%0d ovf=%b full=%b data=%h, required all 0",
                  out_valid, level, overflow, full, out_data);
      end
      @(negedge clk);
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      logic [31:0] exp_w [4];
      bit ok;
      exp_w[0] = 32'd19; exp_w[1] = 32'd22; exp_w[2] = 32'd43; exp_w[3] = 32'd50;
      out_ready = 1'b1;
      set_in(exp_w[0], exp_w[1], exp_w[2], exp_w[3]);
      push_exp(exp_w[0], exp_w[1], exp_w[2], exp_w[3]);
      done = 1'b1;
      tick();
      done = 1'b0;
      n_checks++;
      if (level !== 3'd1) begin
         n_fail++;
         $display("FAIL single_level: got %0d, required 1", level);
      end
      for (int e = 0; e < 4; e++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== exp_w[e] || out_idx !== 2'(e) || out_last !== (e == 3)) begin
            n_fail++;
            $display("FAIL single_timing: cycle %0d valid=%b data=%0d idx=%0d last=%b, required valid=1 data=%0d idx=%0d last=%b",
                     e, out_valid, out_data, out_idx, out_last, exp_w[e], e, (e == 3));
         end
         tick();
      end
      n_checks++;
      if (out_valid !== 1'b0 || level !== 3'd0) begin
         n_fail++;
         $display("FAIL single_idle: valid=%b level=%0d, required 0 0", out_valid, level);
      end
      wait_drain(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL single_drain: %0d words outstanding", sb.size());
      end
   endtask

   task automatic test_backpressure();
      logic [6:0] pat;
      int hs0;
      pat = 7'b1011001;   // applied LSB first: 1,0,0,1,1,0,1
      hs0 = hs_cnt;
      out_ready = 1'b0;
      set_in(1, 2, 3, 4);
      push_exp(1, 2, 3, 4);
      done = 1'b1;
      tick();
      done = 1'b0;
      for (int i = 0; i < 7; i++) begin
         out_ready = pat[i];
         tick();
      end
      out_ready = 1'b0;
      tick();
      n_checks++;
      if (hs_cnt - hs0 != 4 || out_valid !== 1'b0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL backpressure: handshakes=%0d valid=%b pending=%0d, required 4 0 0",
                  hs_cnt - hs0, out_valid, sb.size());
      end
   endtask

   task automatic test_overflow();
      bit ok;
      out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         set_in(k, 2 * k, 3 * k, 4 * k);
         if (k <= 4) push_exp(k, 2 * k, 3 * k, 4 * k);
         done = 1'b1;
         tick();
      end
      done = 1'b0;
      n_checks++;
      if (level !== 3'd4 || full !== 1'b1 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_full: level=%0d full=%b ovf=%b, required 4 1 1", level, full, overflow);
      end
      out_ready = 1'b1;
      wait_drain(ok);
      n_checks++;
      if (!ok || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_drain: drained=%b ovf=%b pending=%0d, required 1 1 0", ok, overflow, sb.size());
      end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      n_checks++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_clear: got %b, required 0", overflow);
      end
   endtask

   task automatic test_push_pop_full();
      bit ok;
      bit found;
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         set_in(32'h100 + k, 32'h200 + k, 32'h300 + k, 32'h400 + k);
         push_exp(32'h100 + k, 32'h200 + k, 32'h300 + k, 32'h400 + k);
         done = 1'b1;
         tick();
      end
      done = 1'b0;
      out_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid === 1'b1 && out_idx === 2'd3) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      n_checks++;
      if (!found || full !== 1'b1) begin
         n_fail++;
         $display("FAIL pushpop_setup: reached_z=%b full=%b, required 1 1", found, full);
      end
      set_in(32'hA, 32'hB, 32'hC, 32'hD);
      push_exp(32'hA, 32'hB, 32'hC, 32'hD);
      done = 1'b1;
      tick();
      done = 1'b0;
      n_checks++;
      if (level !== 3'd4 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL pushpop_level: level=%0d ovf=%b, required 4 0", level, overflow);
      end
      wait_drain(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL pushpop_drain: %0d words outstanding", sb.size());
      end
   endtask

   task automatic test_wrap_sign();
      int sent;
      bit ok;
      sent = 0;
      for (int cyc = 0; cyc < 500 && sent < 10; cyc++) begin
         out_ready = 1'($urandom_range(0, 1));
         if (level < 3'd4 && $urandom_range(0, 2) != 0) begin
            if (sent == 0)      set_in(32'h8000_0000, $urandom, $urandom, 32'hFFFF_FFFF);
            else if (sent == 5) set_in(32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0001);
            else                set_in($urandom, $urandom, $urandom, $urandom);
            push_exp(w, x, y, z);
            done = 1'b1;
            sent++;
         end else begin
            done = 1'b0;
         end
         tick();
      end
      done = 1'b0;
      out_ready = 1'b1;
      wait_drain(ok);
      n_checks++;
      if (sent != 10 || !ok || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap: sent=%0d drained=%b ovf=%b, required 10 1 0", sent, ok, overflow);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_in(32'h50 + k, 32'h60 + k, 32'h70 + k, 32'h80 + k);
         push_exp(32'h50 + k, 32'h60 + k, 32'h70 + k, 32'h80 + k);
         done = 1'b1;
         tick();
      end
      done = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_checks++;
      if (out_idx !== 2'd1 || level !== 3'd3) begin
         n_fail++;
         $display("FAIL midreset_setup: idx=%0d level=%0d, required 1 3", out_idx, level);
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0 || out_data !== '0) begin
         n_fail++;
         $display("FAIL midreset_async: valid=%b level=%0d ovf=%b data=%h, required all 0",
                  out_valid, level, overflow, out_data);
      end
      sb.delete();
      tick();
      tick();
      @(negedge clk);
      reset_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (out_valid !== 1'b0 || level !== 3'd0) begin
            n_fail++;
            $display("FAIL midreset_stale: valid=%b level=%0d, required 0 0", out_valid, level);
         end
      end
      set_in(32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 32'hCAFE_F00D);
      push_exp(32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 32'hCAFE_F00D);
      done = 1'b1;
      tick();
      done = 1'b0;
      wait_drain(ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL midreset_new: %0d words outstanding", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_overflow();
      test_push_pop_full();
      test_wrap_sign();
      test_reset_mid();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL final_scoreboard: %0d words outstanding, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
